// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response port: one request channel (req..wdata, addr_ok)
// and one in-order response channel (data_ok, rdata).
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-requester arbiter onto one SRAM-like port. Accepted requests are held on
// the shared port until addr_ok; an owner FIFO routes in-order responses back.
module sram_req_arbiter #(
  parameter int OUTSTANDING     = 4,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_req_arbiter_if.slave     inst_sram,
  sram_req_arbiter_if.slave     data_sram,
  sram_req_arbiter_if.master    mem,
  output logic                  arb_err
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  state_e                 state_q, state_d;
  req_t                   req_q, req_d;
  logic [OUTSTANDING-1:0] owner_q, owner_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [SW-1:0]          streak_q, streak_d;
  logic                   arb_err_q, arb_err_d;

  logic can_grant, force_inst, gnt_data, gnt_inst, push, pop, head;
  req_t inst_req, data_req;

  assign inst_req = '{wr: inst_sram.wr, size: inst_sram.size, addr: inst_sram.addr,
                      wstrb: inst_sram.wstrb, wdata: inst_sram.wdata};
  assign data_req = '{wr: data_sram.wr, size: data_sram.size, addr: data_sram.addr,
                      wstrb: data_sram.wstrb, wdata: data_sram.wdata};

  // Full check uses the registered count, so a same-cycle pop never frees a slot early.
  assign can_grant  = resetn && (state_q == S_IDLE) && (count_q < CW'(OUTSTANDING));
  assign force_inst = inst_sram.req && (streak_q == SW'(MAX_DATA_STREAK));
  assign gnt_data   = can_grant && data_sram.req && !force_inst;
  assign gnt_inst   = can_grant && inst_sram.req && !gnt_data;
  assign push       = gnt_data || gnt_inst;
  assign pop        = resetn && mem.data_ok && (count_q != '0);
  assign head       = owner_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (push)        state_d = S_ISSUE;
      S_ISSUE: if (mem.addr_ok) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (gnt_data)      req_d = data_req;
    else if (gnt_inst) req_d = inst_req;
  end

  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      owner_d[wr_ptr_q] = gnt_data;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Streak only moves in IDLE; a full FIFO with inst waiting leaves it untouched.
  always_comb begin
    streak_d = streak_q;
    if (state_q == S_IDLE) begin
      if (gnt_inst)
        streak_d = '0;
      else if (gnt_data && inst_sram.req) begin
        if (streak_q < SW'(MAX_DATA_STREAK)) streak_d = streak_q + SW'(1);
      end else if (!inst_sram.req)
        streak_d = '0;
    end
  end

  assign arb_err_d = arb_err_q | (mem.data_ok && (count_q == '0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      owner_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      streak_q  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      owner_q   <= owner_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      streak_q  <= streak_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign mem.req   = resetn && (state_q == S_ISSUE);
  assign mem.wr    = req_q.wr;
  assign mem.size  = req_q.size;
  assign mem.addr  = req_q.addr;
  assign mem.wstrb = req_q.wstrb;
  assign mem.wdata = req_q.wdata;

  assign inst_sram.addr_ok = gnt_inst;
  assign data_sram.addr_ok = gnt_data;
  assign inst_sram.data_ok = pop && !head;
  assign data_sram.data_ok = pop && head;
  assign inst_sram.rdata   = mem.rdata;
  assign data_sram.rdata   = mem.rdata;

  assign arb_err = arb_err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: main thread drives stimulus and pushes
// expected responses; a negedge monitor pops and checks every upstream data_ok.
module tb_sram_req_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic arb_err;

  sram_req_arbiter_if inst_if();
  sram_req_arbiter_if data_if();
  sram_req_arbiter_if mem_if();

  sram_req_arbiter #(.OUTSTANDING(4), .MAX_DATA_STREAK(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inst_sram (inst_if),
    .data_sram (data_if),
    .mem       (mem_if),
    .arb_err   (arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  logic own_q[$];
  int   tests = 0;
  int   failed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (inst_if.data_ok === 1'b1 || data_if.data_ok === 1'b1) begin
      rsp_t e;
      tests++;
      if (inst_if.data_ok === 1'b1 && data_if.data_ok === 1'b1) begin
        failed++;
        $display("FAIL mon_both_data_ok: got inst=1 data=1 expected one-hot");
      end else if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL mon_unexpected_rsp: got data_ok on %s expected none",
                 data_if.data_ok ? "data" : "inst");
      end else begin
        e = exp_q.pop_front();
        if (data_if.data_ok !== e.owner ||
            (e.owner ? data_if.rdata : inst_if.rdata) !== e.rdata) begin
          failed++;
          $display("FAIL mon_rsp: got owner=%0d rdata=%h expected owner=%0d rdata=%h",
                   data_if.data_ok, e.owner ? data_if.rdata : inst_if.rdata, e.owner, e.rdata);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic nxt();
    @(posedge clk); #1;
    mem_if.data_ok = 1'b0;
  endtask

  task automatic set_rsp(input logic owner, input logic [31:0] rd);
    rsp_t e;
    e.owner = owner;
    e.rdata = rd;
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = rd;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    logic o;
    for (int k = 0; k < 16 && own_q.size() > 0; k++) begin
      o = own_q.pop_front();
      set_rsp(o, 32'hD000_0000 + k);
      @(negedge clk);
      nxt();
    end
  endtask

  task automatic issue_one(input logic owner, input logic wr, input logic [31:0] addr,
                           input logic [3:0] wstrb, input logic [31:0] wdata);
    if (owner) begin
      data_if.req = 1'b1; data_if.wr = wr; data_if.addr = addr;
      data_if.wstrb = wstrb; data_if.wdata = wdata; data_if.size = 2'd2;
    end else begin
      inst_if.req = 1'b1; inst_if.wr = wr; inst_if.addr = addr;
      inst_if.wstrb = wstrb; inst_if.wdata = wdata; inst_if.size = 2'd2;
    end
    mem_if.addr_ok = 1'b1;
    @(negedge clk);
    check("io_win_aok",  owner ? data_if.addr_ok : inst_if.addr_ok, 1);
    check("io_lose_aok", owner ? inst_if.addr_ok : data_if.addr_ok, 0);
    own_q.push_back(owner);
    nxt();
    data_if.req = 1'b0;
    inst_if.req = 1'b0;
    @(negedge clk);
    check("io_mem_req",   mem_if.req, 1);
    check("io_mem_addr",  mem_if.addr, addr);
    check("io_mem_wr",    mem_if.wr, wr);
    check("io_mem_wstrb", mem_if.wstrb, wstrb);
    check("io_mem_wdata", mem_if.wdata, wdata);
    check("io_mem_size",  mem_if.size, 2);
    nxt();
  endtask

  initial begin
    int ng;
    logic [9:0] gseq;
    logic [9:0] exp_seq;
    logic o;

    inst_if.req = 1'b1; inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.addr = '0;
    inst_if.wstrb = '0; inst_if.wdata = '0;
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.addr = '0;
    data_if.wstrb = '0; data_if.wdata = '0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = '0;

    // Reset state with both requesters active
    @(negedge clk);
    check("rst_inst_aok", inst_if.addr_ok, 0);
    check("rst_data_aok", data_if.addr_ok, 0);
    check("rst_mem_req",  mem_if.req, 0);
    check("rst_arb_err",  arb_err, 0);
    nxt();
    inst_if.req = 1'b0; data_if.req = 1'b0;
    resetn = 1'b1;
    nxt();

    // 1: inst-only burst, responses two cycles after each grant
    ng = 0;
    mem_if.addr_ok = 1'b1;
    for (int c = 0; c < 7; c++) begin
      inst_if.req  = (ng < 3);
      inst_if.addr = 32'h100 + 4 * ng;
      if (c == 2 || c == 4 || c == 6) set_rsp(1'b0, 32'hA000_0000 + c);
      @(negedge clk);
      check("t1_inst_aok", inst_if.addr_ok, (c == 0 || c == 2 || c == 4));
      check("t1_data_aok", data_if.addr_ok, 0);
      check("t1_mem_req",  mem_if.req, (c == 1 || c == 3 || c == 5));
      if (c == 1 || c == 3 || c == 5) check("t1_mem_addr", mem_if.addr, 32'h100 + 4 * ((c - 1) / 2));
      if (inst_if.addr_ok === 1'b1) ng++;
      nxt();
    end
    inst_if.req = 1'b0;

    // 2: both held, data streak capped at 4
    ng = 0;
    gseq = '0;
    inst_if.req = 1'b1; data_if.req = 1'b1;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      if (own_q.size() > 0) begin
        o = own_q.pop_front();
        set_rsp(o, 32'hB000_0000 + c);
      end
      @(negedge clk);
      if (data_if.addr_ok === 1'b1 || inst_if.addr_ok === 1'b1) begin
        check("t2_onehot", {31'd0, data_if.addr_ok & inst_if.addr_ok}, 0);
        gseq[ng] = data_if.addr_ok;
        own_q.push_back(data_if.addr_ok);
        ng++;
      end
      nxt();
    end
    inst_if.req = 1'b0; data_if.req = 1'b0;
    check("t2_ngrants", ng, 10);
    exp_seq = 10'b0111101111;
    for (int i = 0; i < 10; i++) check("t2_grant_order", gseq[i], exp_seq[i]);
    drain();

    // 3: FIFO full blocks the 5th grant; a pop frees a slot for the next IDLE cycle
    data_if.req = 1'b1; data_if.addr = 32'h2000;
    for (int c = 0; c < 12; c++) begin
      if (c == 10) begin
        o = own_q.pop_front();
        set_rsp(o, 32'hC0DE_0000);
      end
      @(negedge clk);
      check("t3_data_aok", data_if.addr_ok, (c == 0 || c == 2 || c == 4 || c == 6 || c == 11));
      if (data_if.addr_ok === 1'b1) own_q.push_back(1'b1);
      nxt();
    end
    data_if.req = 1'b0;
    check("t3_outstanding", own_q.size(), 4);
    drain();

    // 4: interleaved D rd, I rd, D wr routed in order
    issue_one(1'b1, 1'b0, 32'h0000_1000, 4'b0000, 32'h0);
    issue_one(1'b0, 1'b0, 32'h1c00_0000, 4'b0000, 32'h0);
    issue_one(1'b1, 1'b1, 32'h0000_1004, 4'b0011, 32'h5566_7788);
    o = own_q.pop_front(); set_rsp(o, 32'h1111_1111); @(negedge clk); nxt();
    o = own_q.pop_front(); set_rsp(o, 32'h2222_2222); @(negedge clk); nxt();
    o = own_q.pop_front(); set_rsp(o, 32'h0000_0000); @(negedge clk); nxt();

    // 5: addr_ok withheld for 5 cycles in ISSUE
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h3000;
    mem_if.addr_ok = 1'b0;
    @(negedge clk);
    check("t5_grant", data_if.addr_ok, 1);
    own_q.push_back(1'b1);
    nxt();
    data_if.req = 1'b0; data_if.addr = 32'hDEAD_BEEF;
    inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0040;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("t5_hold_req",  mem_if.req, 1);
      check("t5_hold_addr", mem_if.addr, 32'h3000);
      check("t5_hold_wr",   mem_if.wr, 0);
      check("t5_no_grant",  inst_if.addr_ok, 0);
      nxt();
    end
    mem_if.addr_ok = 1'b1;
    @(negedge clk);
    check("t5_accept_req",   mem_if.req, 1);
    check("t5_accept_nogrt", inst_if.addr_ok, 0);
    nxt();
    @(negedge clk);
    check("t5_idle_req",  mem_if.req, 0);
    check("t5_idle_grant", inst_if.addr_ok, 1);
    own_q.push_back(1'b0);
    nxt();
    inst_if.req = 1'b0;
    @(negedge clk);
    check("t5_inst_addr", mem_if.addr, 32'h1c00_0040);
    nxt();
    drain();

    // 6: reset mid-ISSUE with 2 outstanding, then a stray response
    issue_one(1'b1, 1'b0, 32'h4000, 4'b0000, 32'h0);
    issue_one(1'b0, 1'b0, 32'h1c00_0080, 4'b0000, 32'h0);
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h4008;
    mem_if.addr_ok = 1'b0;
    @(negedge clk);
    check("t6_grant", data_if.addr_ok, 1);
    nxt();
    data_if.req = 1'b0;
    @(negedge clk);
    check("t6_issue_req", mem_if.req, 1);
    #1 resetn = 1'b0;
    #1;
    check("t6_rst_mem_req", mem_if.req, 0);
    check("t6_rst_arb_err", arb_err, 0);
    own_q.delete();
    nxt();
    resetn = 1'b1;
    mem_if.addr_ok = 1'b1;
    nxt();
    mem_if.data_ok = 1'b1;
    mem_if.rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("t6_stray_inst_dok", inst_if.data_ok, 0);
    check("t6_stray_data_dok", data_if.data_ok, 0);
    check("t6_err_before", arb_err, 0);
    nxt();
    check("t6_err_set", arb_err, 1);
    data_if.req = 1'b1; data_if.addr = 32'h5000;
    @(negedge clk);
    check("t6_post_grant", data_if.addr_ok, 1);
    nxt();
    data_if.req = 1'b0;
    nxt();
    check("t6_err_sticky", arb_err, 1);

    check("end_exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
